// File: rtl/vend_pkg.sv
// Shared types, product codes, price table and error codes for the vending sequencer.
package vend_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CREDIT,
        S_VEND,
        S_CHANGE
    } state_e;

    localparam int NPROD = 4;

    localparam logic [2:0] SEL_A = 3'b001;
    localparam logic [2:0] SEL_B = 3'b010;
    localparam logic [2:0] SEL_C = 3'b011;
    localparam logic [2:0] SEL_D = 3'b100;

    localparam logic [1:0] COIN_5  = 2'b01;
    localparam logic [1:0] COIN_10 = 2'b10;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_SOLD = 2'b01;
    localparam logic [1:0] ERR_TMO  = 2'b10;
    localparam logic [1:0] ERR_SEL  = 2'b11;

    // Prices in 5rs units, indexed by product (0=A..3=D)
    localparam logic [4:0] PRICE_TBL [NPROD] = '{5'd1, 5'd2, 5'd3, 5'd4};

    function automatic logic sel_is_valid(input logic [2:0] s);
        return (s == SEL_A) || (s == SEL_B) || (s == SEL_C) || (s == SEL_D);
    endfunction

    function automatic logic [1:0] sel_to_idx(input logic [2:0] s);
        logic [2:0] t;
        t = s - 3'd1;
        return t[1:0];
    endfunction

    function automatic logic [1:0] coin_units(input logic [1:0] c);
        logic [1:0] u;
        unique case (c)
            COIN_5:  u = 2'd1;
            COIN_10: u = 2'd2;
            default: u = 2'd0;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/vend_stock.sv
// Per-product stock counters; a load to an index overrides a same-cycle decrement.
module vend_stock
    import vend_pkg::*;
#(
    parameter int STOCK_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [1:0]         load_idx,
    input  logic [STOCK_W-1:0] load_val,
    input  logic               dec,
    input  logic [1:0]         dec_idx,
    output logic [NPROD-1:0]   nonzero
);

    logic [STOCK_W-1:0] stock_q [NPROD];
    logic [STOCK_W-1:0] stock_d [NPROD];

    always_comb begin
        for (int i = 0; i < NPROD; i++) begin
            stock_d[i] = stock_q[i];
            nonzero[i] = |stock_q[i];
            if (dec && dec_idx == 2'(i) && stock_q[i] != '0) begin
                stock_d[i] = stock_q[i] - 1'b1;
            end
            if (load && load_idx == 2'(i)) begin
                stock_d[i] = load_val;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NPROD; i++) begin
                stock_q[i] <= '1;
            end
        end else begin
            for (int i = 0; i < NPROD; i++) begin
                stock_q[i] <= stock_d[i];
            end
        end
    end

endmodule

// File: rtl/vend_sequencer.sv
// Vending machine sequencer: coin credit, product vend with motor timeout, change eject.
// Optional stock tracking and restock port enabled by defining STOCK_TRACK_EN.
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int MAX_CREDIT    = 20,
    parameter int MOTOR_TIMEOUT = 1000,
    parameter int STOCK_W       = 4
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef STOCK_TRACK_EN
    input  logic               stock_load,
    input  logic [1:0]         stock_idx,
    input  logic [STOCK_W-1:0] stock_val,
`endif
    input  logic [1:0]         coin,
    input  logic [2:0]         select,
    input  logic               sel_valid,
    input  logic               cancel,
    output logic               motor_req,
    input  logic               motor_done,
    output logic               chg_req,
    input  logic               chg_ack,
    output logic [4:0]         credit,
    output logic               busy,
    output logic               coin_reject,
    output logic               vend_done,
    output logic [1:0]         err
);

    localparam int TW = $clog2(MOTOR_TIMEOUT + 1);

    state_e         state_q, state_d;
    logic [4:0]     credit_q, credit_d;
    logic           motor_req_q, motor_req_d;
    logic           chg_req_q, chg_req_d;
    logic           busy_q, busy_d;
    logic           coin_reject_q, coin_reject_d;
    logic           vend_done_q, vend_done_d;
    logic [1:0]     err_q, err_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [1:0]     prod_q, prod_d;

    logic [NPROD-1:0] stock_nz;
    logic             coin_vld;
    logic [5:0]       coin_sum;
    logic             coin_ok;
    logic [1:0]       sel_idx;
    logic [4:0]       sel_price;

    assign coin_vld  = coin_units(coin) != 2'd0;
    assign coin_sum  = {1'b0, credit_q} + {4'b0, coin_units(coin)};
    assign coin_ok   = coin_sum <= 6'(MAX_CREDIT);
    assign sel_idx   = sel_to_idx(select);
    assign sel_price = PRICE_TBL[sel_idx];

`ifdef STOCK_TRACK_EN
    vend_stock #(
        .STOCK_W (STOCK_W)
    ) u_stock (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (stock_load),
        .load_idx (stock_idx),
        .load_val (stock_val),
        .dec      (vend_done_d),
        .dec_idx  (prod_q),
        .nonzero  (stock_nz)
    );
`else
    // Untracked stock never runs out
    assign stock_nz = {NPROD{STOCK_W > 0}};
`endif

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        motor_req_d   = motor_req_q;
        chg_req_d     = chg_req_q;
        coin_reject_d = 1'b0;
        vend_done_d   = 1'b0;
        err_d         = ERR_NONE;
        timer_d       = timer_q;
        prod_d        = prod_q;

        unique case (state_q)
            S_IDLE, S_CREDIT: begin
                if (state_q == S_CREDIT && cancel) begin
                    state_d       = S_CHANGE;
                    chg_req_d     = 1'b1;
                    coin_reject_d = coin_vld;
                end else if (sel_valid) begin
                    coin_reject_d = coin_vld;
                    if (!sel_is_valid(select)) begin
                        err_d = ERR_SEL;
                    end else if (!stock_nz[sel_idx]) begin
                        err_d = ERR_SOLD;
                    end else if (credit_q >= sel_price) begin
                        state_d     = S_VEND;
                        credit_d    = credit_q - sel_price;
                        motor_req_d = 1'b1;
                        prod_d      = sel_idx;
                    end
                end else if (coin_vld) begin
                    if (coin_ok) begin
                        credit_d = coin_sum[4:0];
                        state_d  = S_CREDIT;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end
            S_VEND: begin
                coin_reject_d = coin_vld;
                if (motor_done) begin
                    vend_done_d = 1'b1;
                    motor_req_d = 1'b0;
                    if (credit_q != '0) begin
                        state_d   = S_CHANGE;
                        chg_req_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (timer_q == TW'(MOTOR_TIMEOUT - 1)) begin
                    // Refund the price; the product was never delivered
                    err_d       = ERR_TMO;
                    credit_d    = credit_q + PRICE_TBL[prod_q];
                    motor_req_d = 1'b0;
                    state_d     = S_CHANGE;
                    chg_req_d   = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_CHANGE: begin
                coin_reject_d = coin_vld;
                if (credit_q == '0) begin
                    state_d   = S_IDLE;
                    chg_req_d = 1'b0;
                end else if (chg_ack) begin
                    credit_d = credit_q - 1'b1;
                    if (credit_q == 5'd1) begin
                        state_d   = S_IDLE;
                        chg_req_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d     = S_IDLE;
                credit_d    = '0;
                motor_req_d = 1'b0;
                chg_req_d   = 1'b0;
            end
        endcase

        if (state_d != S_VEND) begin
            timer_d = '0;
        end
        busy_d = (state_d == S_VEND) || (state_d == S_CHANGE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            credit_q      <= '0;
            motor_req_q   <= 1'b0;
            chg_req_q     <= 1'b0;
            busy_q        <= 1'b0;
            coin_reject_q <= 1'b0;
            vend_done_q   <= 1'b0;
            err_q         <= ERR_NONE;
            timer_q       <= '0;
            prod_q        <= '0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            motor_req_q   <= motor_req_d;
            chg_req_q     <= chg_req_d;
            busy_q        <= busy_d;
            coin_reject_q <= coin_reject_d;
            vend_done_q   <= vend_done_d;
            err_q         <= err_d;
            timer_q       <= timer_d;
            prod_q        <= prod_d;
        end
    end

    assign motor_req   = motor_req_q;
    assign chg_req     = chg_req_q;
    assign credit      = credit_q;
    assign busy        = busy_q;
    assign coin_reject = coin_reject_q;
    assign vend_done   = vend_done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed self-checking bench for vend_sequencer with hand-computed expectations.
module tb_vend_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] coin = 2'b00;
    logic [2:0] select = 3'b000;
    logic       sel_valid = 1'b0;
    logic       cancel = 1'b0;
    logic       motor_done = 1'b0;
    logic       chg_ack = 1'b0;
    logic       motor_req;
    logic       chg_req;
    logic [4:0] credit;
    logic       busy;
    logic       coin_reject;
    logic       vend_done;
    logic [1:0] err;
`ifdef STOCK_TRACK_EN
    logic       stock_load = 1'b0;
    logic [1:0] stock_idx = 2'b00;
    logic [3:0] stock_val = 4'h0;
`endif

    int checks = 0;
    int errors = 0;
    int n;

    vend_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef STOCK_TRACK_EN
        .stock_load  (stock_load),
        .stock_idx   (stock_idx),
        .stock_val   (stock_val),
`endif
        .coin        (coin),
        .select      (select),
        .sel_valid   (sel_valid),
        .cancel      (cancel),
        .motor_req   (motor_req),
        .motor_done  (motor_done),
        .chg_req     (chg_req),
        .chg_ack     (chg_ack),
        .credit      (credit),
        .busy        (busy),
        .coin_reject (coin_reject),
        .vend_done   (vend_done),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic coin_in(input logic [1:0] v);
        coin = v;
        cyc();
        coin = 2'b00;
    endtask

    task automatic sel_in(input logic [2:0] s);
        select = s;
        sel_valid = 1'b1;
        cyc();
        sel_valid = 1'b0;
    endtask

    task automatic ack_n(input int k);
        for (int i = 0; i < k; i++) begin
            chg_ack = 1'b1;
            cyc();
            chg_ack = 1'b0;
        end
    endtask

    task automatic done_pulse();
        motor_done = 1'b1;
        cyc();
        motor_done = 1'b0;
    endtask

    task automatic cancel_pulse();
        cancel = 1'b1;
        cyc();
        cancel = 1'b0;
    endtask

    initial begin
        repeat (2) cyc();
        chk("rst_credit", credit, 0);
        chk("rst_motor", motor_req, 0);
        chk("rst_chg", chg_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_vdone", vend_done, 0);
        rst_n = 1'b1;
        cyc();

        // 10 + 5 then C, motor done after 5 cycles
        coin_in(2'b10);
        chk("c10_credit", credit, 2);
        coin_in(2'b01);
        chk("c5_credit", credit, 3);
        sel_in(3'b011);
        chk("vc_credit", credit, 0);
        chk("vc_motor", motor_req, 1);
        chk("vc_busy", busy, 1);
        repeat (4) cyc();
        chk("vc_hold", motor_req, 1);
        done_pulse();
        chk("vc_vdone", vend_done, 1);
        chk("vc_mlow", motor_req, 0);
        chk("vc_idle", busy, 0);
        chk("vc_nochg", chg_req, 0);
        cyc();
        chk("vc_vpulse", vend_done, 0);

        // 30rs then A, change of 5 units
        repeat (3) coin_in(2'b10);
        chk("c30_credit", credit, 6);
        sel_in(3'b001);
        chk("va_credit", credit, 5);
        coin_in(2'b01);
        chk("va_coinrej", coin_reject, 1);
        chk("va_credkeep", credit, 5);
        done_pulse();
        chk("va_chg", chg_req, 1);
        chk("va_busy", busy, 1);
        ack_n(3);
        chk("va_cred2", credit, 2);
        chk("va_chg2", chg_req, 1);
        ack_n(2);
        chk("va_cred0", credit, 0);
        chk("va_chg0", chg_req, 0);
        chk("va_idle", busy, 0);

        // Invalid code, short credit, stray strobes
        coin_in(2'b01);
        sel_in(3'b111);
        chk("inv_err", err, 3);
        chk("inv_credit", credit, 1);
        cyc();
        chk("inv_errclr", err, 0);
        sel_in(3'b100);
        chk("short_motor", motor_req, 0);
        chk("short_credit", credit, 1);
        chk("short_err", err, 0);
        done_pulse();
        chk("stray_done", vend_done, 0);
        ack_n(1);
        chk("stray_ack", credit, 1);
        cancel_pulse();
        chk("cxl_chg", chg_req, 1);
        chk("cxl_busy", busy, 1);
        ack_n(1);
        chk("cxl_cred", credit, 0);
        chk("cxl_idle", busy, 0);
        cancel_pulse();
        chk("idle_cxl", busy, 0);

        // Credit ceiling
        repeat (9) coin_in(2'b10);
        coin_in(2'b01);
        chk("c19", credit, 19);
        coin_in(2'b10);
        chk("c19_rej", coin_reject, 1);
        chk("c19_keep", credit, 19);
        coin_in(2'b01);
        chk("c20", credit, 20);
        chk("c20_norej", coin_reject, 0);
        coin_in(2'b01);
        chk("c20_rej", coin_reject, 1);
        chk("c20_keep", credit, 20);
        cancel_pulse();
        ack_n(20);
        chk("c20_drain", credit, 0);
        chk("c20_idle", busy, 0);

        // Motor timeout on B
        coin_in(2'b10);
        sel_in(3'b010);
        chk("tmo_motor", motor_req, 1);
        chk("tmo_cred0", credit, 0);
        n = 0;
        while (n < 2000 && err !== 2'b10) begin
            cyc();
            n++;
        end
        chk("tmo_cycles", n, 1000);
        chk("tmo_err", err, 2);
        chk("tmo_refund", credit, 2);
        chk("tmo_chg", chg_req, 1);
        chk("tmo_mlow", motor_req, 0);
        cyc();
        chk("tmo_errclr", err, 0);
        done_pulse();
        chk("tmo_late", vend_done, 0);
        ack_n(2);
        chk("tmo_idle", busy, 0);

        // cancel + select + coin together
        coin_in(2'b10);
        coin_in(2'b01);
        cancel = 1'b1;
        sel_valid = 1'b1;
        select = 3'b001;
        coin = 2'b01;
        cyc();
        cancel = 1'b0;
        sel_valid = 1'b0;
        coin = 2'b00;
        chk("pri_chg", chg_req, 1);
        chk("pri_credit", credit, 3);
        chk("pri_rej", coin_reject, 1);
        chk("pri_motor", motor_req, 0);
        ack_n(3);
        chk("pri_idle", busy, 0);

        // Reset in the middle of a vend
        coin_in(2'b10);
        sel_in(3'b001);
        chk("mr_motor", motor_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_mlow", motor_req, 0);
        chk("mr_cred", credit, 0);
        chk("mr_busy", busy, 0);
        cyc();
        rst_n = 1'b1;
        cyc();

`ifdef STOCK_TRACK_EN
        stock_load = 1'b1;
        stock_idx = 2'd3;
        stock_val = 4'd0;
        cyc();
        stock_load = 1'b0;
        coin_in(2'b10);
        coin_in(2'b10);
        sel_in(3'b100);
        chk("sold_err", err, 1);
        chk("sold_credit", credit, 4);
        chk("sold_busy", busy, 0);
        chk("sold_motor", motor_req, 0);
        cancel_pulse();
        ack_n(4);
        stock_load = 1'b1;
        stock_idx = 2'd0;
        stock_val = 4'd1;
        cyc();
        stock_load = 1'b0;
        coin_in(2'b01);
        sel_in(3'b001);
        chk("last_motor", motor_req, 1);
        done_pulse();
        coin_in(2'b01);
        sel_in(3'b001);
        chk("dec_err", err, 1);
        cancel_pulse();
        ack_n(1);
        chk("dec_idle", busy, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vend_sequencer.md
VEND_SEQUENCER -- requirements
Module: vend_sequencer

Interface
REQ-001 Parameter MAX_CREDIT, default 20: credit ceiling in 5rs units.
REQ-002 Parameter MOTOR_TIMEOUT, default 1000: cycles allowed for motor_done after motor_req rises.
REQ-003 Parameter STOCK_W, default 4: width of per-product stock counters.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 coin  in  2  one-cycle coin strobe: 01 = 5rs, 10 = 10rs, 00/11 = no coin.
REQ-007 select  in  3  product code: 001 = A (1 unit), 010 = B (2), 011 = C (3), 100 = D (4); other codes invalid.
REQ-008 sel_valid  in  1  select qualifier, one-cycle strobe.
REQ-009 cancel  in  1  refund request, level sampled each cycle.
REQ-010 motor_req  out  1  dispense motor request, held until motor_done or timeout.
REQ-011 motor_done  in  1  motor completion, one-cycle pulse.
REQ-012 chg_req  out  1  eject one 5rs change coin, held until chg_ack.
REQ-013 chg_ack  in  1  coin ejected, one-cycle pulse.
REQ-014 credit  out  5  current credit in 5rs units.
REQ-015 busy  out  1  high in VEND and CHANGE.
REQ-016 coin_reject  out  1  one-cycle pulse: coin refused.
REQ-017 vend_done  out  1  one-cycle pulse: product dispensed.
REQ-018 err  out  2  one-cycle error code: 01 sold out, 10 motor timeout, 11 invalid select, 00 none.
REQ-019 stock_load, stock_idx[1:0], stock_val[STOCK_W-1:0]  in  restock port (STOCK_TRACK_EN only).

Function
REQ-020 States: IDLE (credit 0), CREDIT (credit > 0), VEND, CHANGE.
REQ-021 IDLE/CREDIT: valid coin adds 1 or 2 units the next cycle; state becomes CREDIT.
REQ-022 A coin that would exceed MAX_CREDIT, or any coin in VEND/CHANGE, is not added; coin_reject pulses the next cycle.
REQ-023 sel_valid with invalid code: err=11, no state change.
REQ-024 sel_valid with valid code, credit >= price, stock nonzero: next cycle enter VEND, credit -= price, motor_req=1.
REQ-025 sel_valid with credit < price: ignored, credit retained.
REQ-026 Zero stock: err=01, credit retained.
REQ-027 VEND: motor_done → vend_done pulse, stock decrement, motor_req low, then CHANGE if credit > 0, else IDLE.
REQ-028 VEND: timer reaching MOTOR_TIMEOUT with no motor_done → err=10, price refunded to credit, stock unchanged, enter CHANGE.
REQ-029 CHANGE: chg_req high while credit > 0; each chg_ack decrements credit by 1; credit 0 → IDLE with chg_req low the same cycle.
REQ-030 cancel in CREDIT → CHANGE the next cycle; cancel ignored in IDLE, VEND, CHANGE.
REQ-031 Same-cycle priority in CREDIT: cancel > sel_valid > coin; a lower-priority coin is rejected.
REQ-032 motor_done outside VEND and chg_ack outside CHANGE are ignored.
REQ-033 Credit arithmetic never wraps; credit <= MAX_CREDIT always.

Reset
REQ-034 rst_n low: state IDLE; credit, motor_req, chg_req, busy, coin_reject, vend_done = 0; err = 00; timer = 0; stock counters = all ones.
REQ-035 Reset mid-VEND or mid-CHANGE drops requests immediately; outstanding credit is lost.

Configuration
REQ-036 STOCK_TRACK_EN defined: four stock counters; stock_load writes stock_val into counter stock_idx (0=A..3=D); a load to the product being dispensed in the same cycle takes precedence over the decrement.
REQ-037 STOCK_TRACK_EN undefined: no counters; restock ports absent; stock is always nonzero; err=01 never occurs.

Structure
REQ-038 Shared package vend_pkg: state enum, product code constants, price table (units), err code constants.
REQ-039 Sub-module vend_stock (stock counter array) instantiated only under STOCK_TRACK_EN.

Verification
REQ-040 Coins 10,5 then select C → credit 3, VEND, motor_done after 5 cycles → vend_done, credit 0, IDLE, stock C -1.
REQ-041 Coins 10,10,10 then select A → credit 5 after vend; three chg_ack pulses → credit 2, chg_req still high; two more → IDLE.
REQ-042 Credit 19 plus 10rs coin → coin_reject, credit 19; 5rs coin → credit 20.
REQ-043 Select B with credit 2, motor_done withheld → err=10 at cycle MOTOR_TIMEOUT, credit 2, CHANGE.
REQ-044 Same cycle cancel+sel_valid+coin with credit 3 → CHANGE, credit 3, coin_reject.
REQ-045 STOCK_TRACK_EN: stock_load D=0, select D with credit 4 → err=01, credit 4, state CREDIT.
